// File: rtl/neuron_layer_ctrl.sv
// Dense-layer sequencer: shares one neuron_b datapath across M neurons, latching the
// layer operands, issuing M start/done jobs in order and packing the ReLU results.
module neuron_layer_ctrl #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int M       = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*WIDTH-1:0]           x_in,
    input  logic [M*N*WIDTH-1:0]         w_in,
    input  logic [M*WIDTH-1:0]           b_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [M*(2*WIDTH+2)-1:0]     y_out,
    output logic                         err,
    output logic                         busy,
    output logic                         n_start,
    output logic [N*WIDTH-1:0]           n_x,
    output logic [N*WIDTH-1:0]           n_w,
    output logic [WIDTH-1:0]             n_b,
    input  logic                         n_done,
    input  logic [2*WIDTH+1:0]           n_y
);

    localparam int YW = 2*WIDTH + 2;
    localparam int RW = N*WIDTH;
    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [KW-1:0]   k;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   x_lat;
    logic [M*RW-1:0] w_lat;
    logic [M*WIDTH-1:0] b_lat;
    logic [M*YW-1:0] y_reg;
    logic            err_reg;

    logic accept;
    logic done_hit;
    logic timeout_hit;
    logic job_end;
    logic last_job;

    // A done seen in the first WAIT cycle may be a sticky level from the previous job.
    always_comb begin
        accept      = (state == S_IDLE) && in_valid;
        done_hit    = (state == S_WAIT) && n_done && (cnt != '0);
        timeout_hit = (state == S_WAIT) && (cnt == CW'(TIMEOUT - 1));
        job_end     = done_hit || timeout_hit;
        last_job    = (k == KW'(M - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (job_end) state_nx = last_job ? S_DONE : S_ISSUE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k       <= '0;
            cnt     <= '0;
            x_lat   <= '0;
            w_lat   <= '0;
            b_lat   <= '0;
            y_reg   <= '0;
            err_reg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x_lat   <= x_in;
                        w_lat   <= w_in;
                        b_lat   <= b_in;
                        y_reg   <= '0;
                        err_reg <= 1'b0;
                        k       <= '0;
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // Done takes priority when it lands on the timeout cycle.
                    for (int unsigned j = 0; j < M; j++) begin
                        if (k == KW'(j)) begin
                            if (done_hit) begin
                                y_reg[j*YW +: YW] <= n_y;
                            end else if (timeout_hit) begin
                                y_reg[j*YW +: YW] <= '0;
                            end
                        end
                    end
                    if (timeout_hit && !done_hit) begin
                        err_reg <= 1'b1;
                    end
                    if (job_end && !last_job) begin
                        k <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state != S_IDLE);
        n_start   = (state == S_ISSUE);
        out_valid = (state == S_DONE);
        y_out     = y_reg;
        err       = err_reg;
        n_x       = x_lat;
        n_w       = '0;
        n_b       = '0;
        for (int unsigned j = 0; j < M; j++) begin
            if (k == KW'(j)) begin
                n_w = w_lat[j*RW +: RW];
                n_b = b_lat[j*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Scoreboard bench for neuron_layer_ctrl driving a behavioural neuron_b stub with
// configurable latency, pulse/level done, and a never-done mode.
module tb_neuron_layer_ctrl;

    localparam int N       = 4;
    localparam int WIDTH   = 8;
    localparam int M       = 3;
    localparam int TIMEOUT = 16;
    localparam int YW      = 2*WIDTH + 2;
    localparam int RW      = N*WIDTH;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [RW-1:0]        x_in = '0;
    logic [M*RW-1:0]      w_in = '0;
    logic [M*WIDTH-1:0]   b_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [M*YW-1:0]      y_out;
    logic                 err;
    logic                 busy;
    logic                 n_start;
    logic [RW-1:0]        n_x;
    logic [RW-1:0]        n_w;
    logic [WIDTH-1:0]     n_b;
    logic                 n_done;
    logic [YW-1:0]        n_y;

    always #5 clk = ~clk;

    neuron_layer_ctrl #(.N(N), .WIDTH(WIDTH), .M(M), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .w_in(w_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .err(err), .busy(busy),
        .n_start(n_start), .n_x(n_x), .n_w(n_w), .n_b(n_b),
        .n_done(n_done), .n_y(n_y)
    );

    typedef struct {
        logic [M*YW-1:0] y;
        logic            err;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [YW-1:0] ref_neuron(input logic [RW-1:0] x, input logic [RW-1:0] w,
                                                 input logic [WIDTH-1:0] b);
        int acc;
        acc = int'($signed(b));
        for (int i = 0; i < N; i++)
            acc += int'($signed(x[i*WIDTH +: WIDTH])) * int'($signed(w[i*WIDTH +: WIDTH]));
        return (acc < 0) ? '0 : YW'(acc);
    endfunction

    // neuron_b stub: result appears stub_lat cycles after the start is sampled
    int          stub_lat   = 2;
    bit          stub_never = 1'b0;
    bit          stub_level = 1'b0;
    logic        inj_done   = 1'b0;
    logic        done_r     = 1'b0;
    logic [YW-1:0] y_s      = '0;
    logic [YW-1:0] pend_y   = '0;
    bit          pend       = 1'b0;
    bit          start_d    = 1'b0;
    int          cnt_s      = 0;

    always @(posedge clk) begin
        start_d <= n_start;
        if (start_d && stub_level) done_r <= 1'b0;
        if (!stub_level) done_r <= 1'b0;
        if (n_start) begin
            pend   <= !stub_never;
            cnt_s  <= stub_lat;
            pend_y <= ref_neuron(n_x, n_w, n_b);
        end else if (pend) begin
            if (cnt_s <= 1) begin
                pend   <= 1'b0;
                done_r <= 1'b1;
                y_s    <= pend_y;
            end else begin
                cnt_s <= cnt_s - 1;
            end
        end
    end

    assign n_done = done_r | inj_done;
    assign n_y    = y_s;

    // Output monitor: latency and start count on out_valid rise, scoreboard pop on handshake
    int   cyc = 0;
    int   acc_cyc = 0;
    int   nstarts = 0;
    bit   ov_d = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            ov_d    = 1'b0;
            nstarts = 0;
        end else begin
            if (n_start) nstarts++;
            if (in_valid && in_ready) begin
                acc_cyc = cyc;
                nstarts = 0;
            end
            if (out_valid && !ov_d) begin
                if (sb.size() == 0) begin
                    check_eq("sb_empty_at_valid", 64'(out_valid), 64'(0));
                end else begin
                    check_eq("latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
                    check_eq("n_start_count", 64'(nstarts), 64'(M));
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 64'(out_valid), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("y_out", 64'(y_out), 64'(mon_e.y));
                    check_eq("err", 64'(err), 64'(mon_e.err));
                end
            end
            ov_d = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [RW-1:0] x, input logic [M*RW-1:0] w, input logic [M*WIDTH-1:0] b);
        exp_t e;
        int   d;
        bit   to;
        to    = stub_never || (stub_lat + 1 > TIMEOUT);
        d     = to ? TIMEOUT : stub_lat + 1;
        e.y   = '0;
        e.err = to;
        e.lat = M*(1 + d) + 1;
        for (int k = 0; k < M; k++)
            if (!to) e.y[k*YW +: YW] = ref_neuron(x, w[k*RW +: RW], b[k*WIDTH +: WIDTH]);
        sb.push_back(e);
    endtask

    // Present a job, wait (bounded) for in_ready, return just after the accepting edge.
    task automatic offer(input logic [RW-1:0] x, input logic [M*RW-1:0] w, input logic [M*WIDTH-1:0] b);
        x_in = x; w_in = w; b_in = b;
        in_valid = 1'b1;
        push_job(x, w, b);
        for (int i = 0; i < 300 && !in_ready; i++) tick();
        check_eq("accept_wait", 64'(in_ready), 64'(1));
        tick();
    endtask

    task automatic wait_out();
        for (int i = 0; i < 300 && !out_valid; i++) tick();
        check_eq("out_valid_wait", 64'(out_valid), 64'(1));
    endtask

    logic [RW-1:0]      t1_x;
    logic [M*RW-1:0]    t1_w;
    logic [M*WIDTH-1:0] t1_b;
    logic [M*YW-1:0]    hold_y;
    int                 seen;

    initial begin
        t1_x = {8'sd1, 8'sd2, 8'sd3, 8'sd4};
        t1_w = {{8'sd5, 8'sd4, 8'sd3, 8'sd2}, {4{8'hFF}}, {4{8'sd1}}};
        t1_b = {8'sd3, 8'hFF, 8'sd5};

        // reset state
        tick(); tick();
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_n_start", 64'(n_start), 64'(0));
        check_eq("rst_y_out", 64'(y_out), 64'(0));
        rst = 1'b1;
        tick();

        // test 1: reference layer, pulse done
        offer(t1_x, t1_w, t1_b);
        in_valid = 1'b0;
        wait_out();
        check_eq("t1_y0", 64'(y_out[0*YW +: YW]), 64'(15));
        check_eq("t1_y1", 64'(y_out[1*YW +: YW]), 64'(0));
        check_eq("t1_y2", 64'(y_out[2*YW +: YW]), 64'(33));
        check_eq("t1_err", 64'(err), 64'(0));
        tick();
        check_eq("t1_idle_valid", 64'(out_valid), 64'(0));
        check_eq("t1_idle_ready", 64'(in_ready), 64'(1));

        // sticky level done: stale level in the first WAIT cycle must be ignored
        stub_level = 1'b1;
        offer(t1_x, t1_w, t1_b);
        in_valid = 1'b0;
        wait_out();
        tick();
        stub_level = 1'b0;

        // test 2: all zero
        offer('0, '0, '0);
        in_valid = 1'b0;
        wait_out();
        check_eq("t2_y", 64'(y_out), 64'(0));
        tick();

        // test 3: consumer stalls for 10 cycles in DONE
        out_ready = 1'b0;
        offer(RW'($urandom), {$urandom, $urandom, $urandom}, (M*WIDTH)'($urandom));
        in_valid = 1'b0;
        hold_y = sb[0].y;
        wait_out();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t3_hold_valid", 64'(out_valid), 64'(1));
            check_eq("t3_hold_y", 64'(y_out), 64'(hold_y));
            check_eq("t3_hold_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        tick();
        check_eq("t3_release_valid", 64'(out_valid), 64'(0));
        check_eq("t3_release_ready", 64'(in_ready), 64'(1));

        // test 4: neuron never answers
        stub_never = 1'b1;
        offer(t1_x, t1_w, t1_b);
        in_valid = 1'b0;
        wait_out();
        check_eq("t4_err", 64'(err), 64'(1));
        check_eq("t4_y", 64'(y_out), 64'(0));
        tick();
        stub_never = 1'b0;

        // done landing on the timeout cycle wins
        stub_lat = TIMEOUT - 1;
        offer(t1_x, t1_w, t1_b);
        in_valid = 1'b0;
        wait_out();
        check_eq("tw_err", 64'(err), 64'(0));
        tick();
        stub_lat = 2;

        // test 5: reset in WAIT of k=1, then stray done pulses
        offer(t1_x, t1_w, t1_b);
        in_valid = 1'b0;
        seen = (n_start === 1'b1) ? 1 : 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            tick();
            if (n_start) seen++;
        end
        check_eq("t5_reach_k1", 64'(seen), 64'(2));
        tick();
        rst = 1'b0;
        #1;
        check_eq("t5_busy", 64'(busy), 64'(0));
        check_eq("t5_in_ready", 64'(in_ready), 64'(1));
        check_eq("t5_n_start", 64'(n_start), 64'(0));
        check_eq("t5_y_out", 64'(y_out), 64'(0));
        check_eq("t5_err", 64'(err), 64'(0));
        check_eq("t5_n_w", 64'(n_w), 64'(0));
        check_eq("t5_n_x", 64'(n_x), 64'(0));
        sb.delete();
        tick();
        rst = 1'b1;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        tick();
        check_eq("t5_late_done_busy", 64'(busy), 64'(0));
        check_eq("t5_late_done_y", 64'(y_out), 64'(0));
        offer(t1_x, t1_w, t1_b);
        in_valid = 1'b0;
        wait_out();
        tick();

        // test 6: back-to-back with in_valid held high
        offer(t1_x, t1_w, t1_b);
        x_in = {8'sd7, 8'hFD, 8'sd2, 8'sd9};
        w_in = {$urandom, $urandom, $urandom};
        b_in = (M*WIDTH)'($urandom);
        push_job(x_in, w_in, b_in);
        wait_out();
        tick();
        check_eq("t6_bubble_ready", 64'(in_ready), 64'(1));
        tick();
        check_eq("t6_second_accept", 64'(busy), 64'(1));
        in_valid = 1'b0;
        wait_out();
        tick();

        // random layers with varied latency
        for (int r = 0; r < 3; r++) begin
            stub_lat = int'($urandom_range(2, 5));
            offer(RW'($urandom), {$urandom, $urandom, $urandom}, (M*WIDTH)'($urandom));
            in_valid = 1'b0;
            wait_out();
            tick();
        end

        check_eq("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

endmodule
